fp_add_issue: RTL and testbench

FP_ADD_ISSUE -- requirements
Module: fp_add_issue

---
 rtl/fp_issue_pkg.sv | 19 +
 rtl/fp_issue_fifo.sv | 65 ++++++
 rtl/fp_add_issue.sv | 148 ++++++++++++++
 tb/tb_fp_add_issue.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_issue_pkg.sv
// Shared types, FP16 field widths and the zero-detect helper for the FP add issue block.
package fp_issue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } issue_state_e;

  localparam int unsigned FP16_W     = 16;
  localparam int unsigned FP16_EXP_W = 5;
  localparam int unsigned FP16_MAN_W = 10;

  // +0 and -0 both have all exponent and mantissa bits clear; the sign is ignored.
  function automatic logic fp16_is_zero(input logic [FP16_W-1:0] data);
    return (data[FP16_EXP_W+FP16_MAN_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/fp_issue_fifo.sv
// Operand-pair FIFO: parallel a/b storage, wrapping pointers and an entry count.
module fp_issue_fifo
  import fp_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_wr_a,
  input  logic [DATA_W-1:0]          i_wr_b,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_rd_a,
  output logic [DATA_W-1:0]          o_rd_b,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem_a [DEPTH];
  logic [DATA_W-1:0] r_mem_b [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage needs no reset: an entry is only read once the count covers it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= i_wr_a;
      r_mem_b[r_wr_ptr] <= i_wr_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_a      = r_mem_a[r_rd_ptr];
  assign o_rd_b      = r_mem_b[r_rd_ptr];
  assign o_occupancy = r_count;

endmodule

// File: rtl/fp_add_issue.sv
// Queues FP16 operand pairs and issues them one at a time to an external FP add wrapper.
// Define FP_ZERO_BYPASS_EN to answer pairs with a +/-0 operand directly, without issuing them.
module fp_add_issue
  import fp_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  output logic                   fp_en,
  output logic [DATA_W-1:0]      fp_a,
  output logic [DATA_W-1:0]      fp_b,
  input  logic                   fp_stall,
  input  logic [DATA_W-1:0]      fp_q,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_q,
  output logic [$clog2(DEPTH):0] occupancy
);

  issue_state_e      r_state;
  issue_state_e      w_state_nxt;
  logic              r_fp_en;
  logic [DATA_W-1:0] r_fp_a;
  logic [DATA_W-1:0] r_fp_b;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_q;

  logic              w_fp_en;
  logic [DATA_W-1:0] w_fp_a;
  logic [DATA_W-1:0] w_fp_b;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_q;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic [DATA_W-1:0] w_head_a;
  logic [DATA_W-1:0] w_head_b;

  assign in_ready = !w_full;

  fp_issue_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (in_valid),
    .i_wr_a      (in_a),
    .i_wr_b      (in_b),
    .i_pop       (w_pop),
    .o_rd_a      (w_head_a),
    .o_rd_b      (w_head_b),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_occupancy (occupancy)
  );

`ifdef FP_ZERO_BYPASS_EN
  logic w_head_a_zero;
  logic w_head_b_zero;
  assign w_head_a_zero = fp16_is_zero(FP16_W'(w_head_a));
  assign w_head_b_zero = fp16_is_zero(FP16_W'(w_head_b));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_fp_en     <= 1'b0;
      r_fp_a      <= '0;
      r_fp_b      <= '0;
      r_out_valid <= 1'b0;
      r_out_q     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fp_en     <= w_fp_en;
      r_fp_a      <= w_fp_a;
      r_fp_b      <= w_fp_b;
      r_out_valid <= w_out_valid;
      r_out_q     <= w_out_q;
    end
  end

  // Next state and next register values; operands and result hold unless explicitly loaded.
  always_comb begin
    w_state_nxt = r_state;
    w_fp_en     = 1'b0;
    w_fp_a      = r_fp_a;
    w_fp_b      = r_fp_b;
    w_out_valid = r_out_valid;
    w_out_q     = r_out_q;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !r_out_valid) begin
`ifdef FP_ZERO_BYPASS_EN
          if (w_head_a_zero || w_head_b_zero) begin
            w_out_q     = w_head_a_zero ? w_head_b : w_head_a;
            w_out_valid = 1'b1;
            w_pop       = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_fp_en     = 1'b1;
            w_fp_a      = w_head_a;
            w_fp_b      = w_head_b;
            w_state_nxt = ISSUE;
          end
`else
          w_fp_en     = 1'b1;
          w_fp_a      = w_head_a;
          w_fp_b      = w_head_b;
          w_state_nxt = ISSUE;
`endif
        end
      end
      ISSUE: begin
        // The in-flight pair stays at the FIFO head until the wrapper completes it.
        if (fp_stall) begin
          w_fp_en = 1'b1;
        end else begin
          w_out_q     = fp_q;
          w_out_valid = 1'b1;
          w_pop       = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (r_out_valid && out_ready) begin
          w_out_valid = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign fp_en     = r_fp_en;
  assign fp_a      = r_fp_a;
  assign fp_b      = r_fp_b;
  assign out_valid = r_out_valid;
  assign out_q     = r_out_q;

endmodule

// File: tb/tb_fp_add_issue.sv
// Randomised bench for fp_add_issue with a pair scoreboard and a stalling FP add wrapper model.
module tb_fp_add_issue;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              fp_en;
  logic [DATA_W-1:0] fp_a;
  logic [DATA_W-1:0] fp_b;
  logic              fp_stall;
  logic [DATA_W-1:0] fp_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_q;
  logic [$clog2(DEPTH):0] occupancy;

  fp_add_issue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .fp_en     (fp_en),
    .fp_a      (fp_a),
    .fp_b      (fp_b),
    .fp_stall  (fp_stall),
    .fp_q      (fp_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } pair_t;

  int n_checks = 0;
  int n_fails  = 0;
  int force_stall = -1;
  int wrap_stall_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stand-in wrapper arithmetic; gives 1.0 + 2.0 = 3.0 (0x3C00 + 0x4000 -> 0x4200).
  function automatic logic [15:0] wrap_sum(input logic [15:0] a, input logic [15:0] b);
    return a + b + 16'hC600;
  endfunction

  function automatic bit is_zero(input logic [15:0] v);
    return (v & 16'h7FFF) == 16'h0000;
  endfunction

  function automatic logic [15:0] ref_result(input logic [15:0] a, input logic [15:0] b);
`ifdef FP_ZERO_BYPASS_EN
    if (is_zero(a)) return b;
    if (is_zero(b)) return a;
`endif
    return wrap_sum(a, b);
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom % 8)
      0:       return 16'h0000;
      1:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // FP add wrapper model: stalls a chosen number of cycles per issue, junk when idle.
  initial begin : wrapper
    bit prev_en;
    int stall_left;
    prev_en = 1'b0;
    stall_left = 0;
    fp_stall = 1'b0;
    fp_q = '0;
    forever begin
      @(negedge clk);
      #1;
      if (fp_en && !prev_en) begin
        stall_left = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 2));
        wrap_stall_n = stall_left;
      end else if (fp_en && stall_left > 0) begin
        stall_left--;
      end
      if (fp_en) begin
        fp_stall = (stall_left > 0);
        fp_q = wrap_sum(fp_a, fp_b);
      end else begin
        fp_stall = 1'($urandom % 2);
        fp_q = 16'($urandom);
      end
      prev_en = fp_en;
    end
  end

  // Scoreboard: at each falling edge, inputs show what the last rising edge used.
  initial begin : monitor
    pair_t mq[$];
    pair_t pr;
    bit p_out_valid, p_in_ready, p_fp_en;
    logic [15:0] p_out_q;
    int lat;
    bit lat_active;
    bit hs_pending;
    lat = 0;
    lat_active = 1'b0;
    hs_pending = 1'b0;
    p_out_valid = 1'b0;
    p_in_ready = 1'b1;
    p_fp_en = 1'b0;
    p_out_q = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mq.delete();
        lat_active = 1'b0;
        hs_pending = 1'b0;
      end else begin
        if (hs_pending) begin
          check_eq("issue_after_hs", 32'(fp_en || (out_valid && !p_out_valid)), 32'd1);
          hs_pending = 1'b0;
        end
        if (lat_active) lat++;
        if (p_out_valid && !out_ready) begin
          check_eq("hold_q", 32'(out_q), 32'(p_out_q));
          check_eq("hold_valid", 32'(out_valid), 32'd1);
        end
        if (out_valid && !p_out_valid) begin
          if (mq.size() == 0) begin
            check_eq("spurious_result", 32'd1, 32'd0);
          end else begin
            pr = mq.pop_front();
            check_eq("result_q", 32'(out_q), 32'(ref_result(pr.a, pr.b)));
          end
          if (lat_active) begin
            check_eq("latency", 32'(lat), 32'(wrap_stall_n + 1));
            lat_active = 1'b0;
          end
        end
        if (in_valid && p_in_ready) mq.push_back({in_a, in_b});
        check_eq("occupancy", 32'(occupancy), 32'(mq.size()));
        check_eq("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        check_eq("en_vs_valid", 32'(fp_en && out_valid), 32'd0);
        if (fp_en && !p_fp_en) begin
          if (mq.size() == 0) begin
            check_eq("issue_empty", 32'd1, 32'd0);
          end else begin
            check_eq("fp_a", 32'(fp_a), 32'(mq[0].a));
            check_eq("fp_b", 32'(fp_b), 32'(mq[0].b));
`ifdef FP_ZERO_BYPASS_EN
            check_eq("issue_zero", 32'(is_zero(mq[0].a) || is_zero(mq[0].b)), 32'd0);
`endif
          end
          lat = 0;
          lat_active = 1'b1;
        end
        if (p_out_valid && out_ready) begin
          check_eq("hs_clear", 32'(out_valid), 32'd0);
          if (mq.size() > 0) hs_pending = 1'b1;
        end
      end
      p_out_valid = out_valid;
      p_in_ready = in_ready;
      p_fp_en = fp_en;
      p_out_q = out_q;
    end
  end

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input string tag);
    bit acc, ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 60; i++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_out_valid(input int max_cyc, output bit seen_en, output int cyc);
    seen_en = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < max_cyc) begin
      tick();
      cyc++;
      seen_en = seen_en | fp_en;
    end
    check_eq("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    while ((occupancy != 0 || out_valid) && c < 300) begin
      tick();
      c++;
    end
    check_eq("drain", 32'(occupancy != 0 || out_valid), 32'd0);
  endtask

  initial begin : stimulus
    bit seen_en, acc;
    int cyc;
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_occupancy", 32'(occupancy), 32'd0);
    check_eq("rst_fp_en", 32'(fp_en), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_q", 32'(out_q), 32'd0);
    check_eq("rst_fp_ab", 32'({fp_a, fp_b}), 32'd0);
    reset = 1'b0;

    // Directed 1.0 + 2.0 with a one-cycle wrapper stall; result left waiting.
    force_stall = 1;
    push_pair(16'h3C00, 16'h4000, "dir_push");
    wait_out_valid(20, seen_en, cyc);
    check_eq("dir_result", 32'(out_q), 32'h4200);
    force_stall = -1;

    // Fill the FIFO behind the held result; the fifth pair must wait.
    for (int i = 0; i < 4; i++) push_pair(16'h3C01 + 16'(i), 16'h4100 + 16'(i), "fill_push");
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    check_eq("full_occupancy", 32'(occupancy), 32'd4);
    in_valid = 1'b1;
    in_a = 16'h3555;
    in_b = 16'h4AAA;
    repeat (8) tick();
    check_eq("held_in_ready", 32'(in_ready), 32'd0);
    check_eq("held_q", 32'(out_q), 32'h4200);
    check_eq("held_fp_en", 32'(fp_en), 32'd0);
    out_ready = 1'b1;
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 40) begin
      acc = in_ready;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("fifth_accept", 32'(acc), 32'd1);
    drain();

    // Random traffic with back-pressure, zero operands and random stalls.
    acc = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!(in_valid && !acc)) begin
        in_valid = 1'($urandom % 2);
        in_a = rand_op();
        in_b = rand_op();
      end
      out_ready = (($urandom % 4) != 0);
      acc = in_valid && in_ready;
      tick();
    end
    drain();

    // Reset while a pair is in flight and two more are queued.
    force_stall = 6;
    push_pair(16'h3800, 16'h3900, "rst_push0");
    push_pair(16'h3A00, 16'h3B00, "rst_push1");
    push_pair(16'h3C00, 16'h3D00, "rst_push2");
    check_eq("pre_rst_fp_en", 32'(fp_en), 32'd1);
    check_eq("pre_rst_occ", 32'(occupancy), 32'd3);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_fp_en", 32'(fp_en), 32'd0);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_occ", 32'(occupancy), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) tick();
    reset = 1'b0;
    force_stall = -1;
    out_ready = 1'b1;
    seen_en = 1'b0;
    repeat (10) begin
      tick();
      seen_en = seen_en | fp_en | out_valid;
    end
    check_eq("post_rst_quiet", 32'(seen_en), 32'd0);

    // Signed-zero operand: bypassed when enabled, issued otherwise.
    push_pair(16'h8000, 16'h4500, "zero_push");
    wait_out_valid(20, seen_en, cyc);
`ifdef FP_ZERO_BYPASS_EN
    check_eq("zero_q", 32'(out_q), 32'h4500);
    check_eq("zero_fp_en", 32'(seen_en), 32'd0);
    check_eq("zero_latency", 32'(cyc), 32'd1);
`else
    check_eq("zero_q", 32'(out_q), 32'(wrap_sum(16'h8000, 16'h4500)));
    check_eq("zero_fp_en", 32'(seen_en), 32'd1);
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
